usb_rx_bit_decoder: RTL and testbench

Front end of the USB receive path, directly upstream of `crc_16_checker`. It samples the synchronized D+/D- pair on a sample strobe and performs NRZI decoding, SYNC detection and bit unstuffing. It emits one serial data bit per valid bit time as `data_out` with a `data_valid` strobe, which drives the checker's `data_in`/`ena`. It also flags end-of-packet (`eop`) and bit-stuff violations.

---
 rtl/usb_rx_bit_decoder.sv | 169 ++++++++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_bit_decoder.sv
// USB receive front end: NRZI decode, SYNC detect, bit unstuffing and EOP detection.
// Define USB_RX_STUFF_ERR_EN to treat a seventh consecutive one as a stuff error.
//
// state    | meaning
// IDLE     | bus idle, waiting for the first SYNC K
// SYNC     | counting the seven SYNC zeros and the closing one
// DATA     | emitting payload bits and dropping stuffed zeros
// SE0_1    | one SE0 seen, a second one completes the EOP
// EOP_WAIT | EOP done, waiting for J to return to idle
// ERR      | packet corrupt, waiting for SE0,SE0 to close it
module usb_rx_bit_decoder (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    output logic data_out,
    output logic data_valid,
    output logic eop,
    output logic stuff_err,
    output logic rcv_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_SE0_1,
        ST_EOP_WAIT,
        ST_ERR
    } state_t;

    state_t     state_q;
    logic       prev_dp_q;
    logic [2:0] zero_cnt_q;
    logic [2:0] ones_cnt_q;
    logic       err_se0_q;
    logic       data_out_q;
    logic       data_valid_q;
    logic       eop_q;
    logic       rcv_active_q;
`ifdef USB_RX_STUFF_ERR_EN
    logic       stuff_err_q;
`endif

    logic line_j;
    logic line_k;
    logic line_se0;
    logic line_se1;
    logic decoded;

    assign line_j   = d_plus & ~d_minus;
    assign line_k   = ~d_plus & d_minus;
    assign line_se0 = ~d_plus & ~d_minus;
    assign line_se1 = d_plus & d_minus;
    assign decoded  = (d_plus == prev_dp_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            prev_dp_q    <= 1'b1;
            zero_cnt_q   <= 3'd0;
            ones_cnt_q   <= 3'd0;
            err_se0_q    <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            eop_q        <= 1'b0;
            rcv_active_q <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_err_q  <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            eop_q        <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_err_q  <= 1'b0;
`endif
            if (shift_enable) begin
                // SE0 leaves the line idle-high for decoding the next bit
                prev_dp_q <= line_se0 ? 1'b1 : d_plus;
                err_se0_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (line_k) begin
                            state_q      <= ST_SYNC;
                            rcv_active_q <= 1'b1;
                            zero_cnt_q   <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (line_se0 || line_se1) begin
                            state_q <= ST_ERR;
                        end else if (!decoded && zero_cnt_q != 3'd7) begin
                            zero_cnt_q <= zero_cnt_q + 3'd1;
                        end else if (decoded && zero_cnt_q == 3'd7) begin
                            state_q    <= ST_DATA;
                            ones_cnt_q <= 3'd1;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                    ST_DATA: begin
                        if (line_se0) begin
                            state_q <= ST_SE0_1;
                        end else if (line_se1) begin
                            state_q <= ST_ERR;
                        end else if (decoded) begin
                            if (ones_cnt_q == 3'd6) begin
`ifdef USB_RX_STUFF_ERR_EN
                                stuff_err_q <= 1'b1;
                                state_q     <= ST_ERR;
`else
                                data_out_q   <= 1'b1;
                                data_valid_q <= 1'b1;
`endif
                            end else begin
                                ones_cnt_q   <= ones_cnt_q + 3'd1;
                                data_out_q   <= 1'b1;
                                data_valid_q <= 1'b1;
                            end
                        end else begin
                            ones_cnt_q <= 3'd0;
                            if (ones_cnt_q != 3'd6) begin
                                data_out_q   <= 1'b0;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                    ST_SE0_1: begin
                        if (line_se0) begin
                            eop_q   <= 1'b1;
                            state_q <= ST_EOP_WAIT;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                    ST_EOP_WAIT: begin
                        if (line_j) begin
                            state_q      <= ST_IDLE;
                            rcv_active_q <= 1'b0;
                        end else if (line_k || line_se1) begin
                            state_q <= ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        if (line_se0 && err_se0_q) begin
                            eop_q   <= 1'b1;
                            state_q <= ST_EOP_WAIT;
                        end else if (line_se0) begin
                            err_se0_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign eop        = eop_q;
    assign rcv_active = rcv_active_q;
`ifdef USB_RX_STUFF_ERR_EN
    assign stuff_err  = stuff_err_q;
`else
    assign stuff_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench for usb_rx_bit_decoder: packets are built by a NRZI/bit-stuffing encoder and
// the decoded stream is compared with the original payload bits.
module tb_usb_rx_bit_decoder;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;

    logic clk;
    logic n_rst;
    logic d_plus;
    logic d_minus;
    logic shift_enable;
    logic data_out;
    logic data_valid;
    logic eop;
    logic stuff_err;
    logic rcv_active;

    usb_rx_bit_decoder dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .shift_enable (shift_enable),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .eop          (eop),
        .stuff_err    (stuff_err),
        .rcv_active   (rcv_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] sym_q[$];
    bit         exp_q[$];
    bit         got_q[$];
    logic [7:0] bytes_q[$];
    bit         line_lvl;
    int         ones_run;

    int   eop_cnt        = 0;
    int   serr_cnt       = 0;
    int   nostrobe_viol  = 0;
    int   hold_viol      = 0;
    int   overlap_viol   = 0;
    logic se_at_edge     = 1'b0;
    logic last_dout      = 1'b0;
    logic obs_eop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collects emitted bits and pulses, and flags protocol-level misbehaviour.
    always @(posedge clk) se_at_edge = shift_enable;

    always @(negedge clk) begin
        if (!n_rst) begin
            last_dout = 1'b0;
        end else begin
            if (data_valid) begin
                got_q.push_back(data_out);
                last_dout = data_out;
            end else if (data_out !== last_dout) begin
                hold_viol++;
            end
            if (eop) eop_cnt++;
            if (stuff_err) serr_cnt++;
            if ((data_valid || eop || stuff_err) && !se_at_edge) nostrobe_viol++;
            if (data_valid && (eop || stuff_err)) overlap_viol++;
        end
    end

    task automatic send_sym(input logic [1:0] sym);
        int gap;
        d_plus       = sym[1];
        d_minus      = sym[0];
        shift_enable = 1'b1;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        obs_eop      = eop;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            d_plus  = 1'($urandom_range(0, 1));
            d_minus = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) send_sym(sym_q[i]);
    endtask

    task automatic add_nrzi(input bit b);
        if (!b) line_lvl = ~line_lvl;
        sym_q.push_back(line_lvl ? SYM_J : SYM_K);
    endtask

    task automatic start_packet();
        sym_q.delete();
        exp_q.delete();
        got_q.delete();
        eop_cnt  = 0;
        serr_cnt = 0;
        line_lvl = 1'b1;
        for (int i = 0; i < 7; i++) add_nrzi(1'b0);
        add_nrzi(1'b1);
        ones_run = 1;
    endtask

    task automatic add_data(input bit b, input bit stuff);
        add_nrzi(b);
        ones_run = b ? ones_run + 1 : 0;
        if (stuff && ones_run == 6) begin
            add_nrzi(1'b0);
            ones_run = 0;
        end
    endtask

    task automatic add_eop();
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_J);
    endtask

    task automatic compare_bits(input string tag);
        int n;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_bit"}, got_q[i], exp_q[i]);
    endtask

    task automatic close_packet(input string tag);
        play(sym_q.size() - 1);
        check_eq({tag, "_eop_at_2nd_se0"}, obs_eop, 1'b1);
        check_eq({tag, "_active_before_j"}, rcv_active, 1'b1);
        send_sym(sym_q[sym_q.size() - 1]);
        check_eq({tag, "_active_after_j"}, rcv_active, 1'b0);
        check_eq({tag, "_eop_count"}, eop_cnt, 1);
    endtask

    task automatic run_packet(input string tag);
        start_packet();
        foreach (bytes_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back(bytes_q[k][b]);
                add_data(bytes_q[k][b], 1'b1);
            end
        end
        add_eop();
        close_packet(tag);
        compare_bits(tag);
        check_eq({tag, "_stuff_err"}, serr_cnt, 0);
    endtask

    initial begin
        logic [7:0] rb;
        n_rst        = 1'b0;
        d_plus       = 1'b1;
        d_minus      = 1'b0;
        shift_enable = 1'b0;
        #12;
        check_eq("reset_outputs", {data_out, data_valid, eop, stuff_err, rcv_active}, 5'b0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset_outputs", {data_out, data_valid, eop, stuff_err, rcv_active}, 5'b0);

        bytes_q = '{8'hA5};
        run_packet("a5");

        bytes_q = '{8'hFF, 8'h00};
        run_packet("ff00_stuffed");

        for (int p = 0; p < 10; p++) begin
            int nb;
            bytes_q.delete();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                rb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                bytes_q.push_back(rb);
            end
            run_packet("rand");
        end

        // Seven decoded ones after SYNC: no stuffed zero inserted.
        start_packet();
        for (int i = 0; i < 7; i++) add_data(1'b1, 1'b0);
`ifdef USB_RX_STUFF_ERR_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
`else
        for (int i = 0; i < 7; i++) exp_q.push_back(1'b1);
`endif
        add_eop();
        close_packet("seven_ones");
        compare_bits("seven_ones");
`ifdef USB_RX_STUFF_ERR_EN
        check_eq("seven_ones_stuff_err", serr_cnt, 1);
`else
        check_eq("seven_ones_stuff_err", serr_cnt, 0);
`endif

        // Corrupted SYNC followed by line junk, then a real EOP.
        start_packet();
        sym_q.delete();
        sym_q = '{SYM_K, SYM_J, SYM_K, SYM_K, SYM_J};
        for (int i = 0; i < 5; i++) sym_q.push_back($urandom_range(0, 1) ? SYM_J : SYM_K);
        sym_q.push_back(SYM_SE1);
        sym_q.push_back(SYM_K);
        add_eop();
        close_packet("bad_sync");
        compare_bits("bad_sync");

        // Single SE0 glitch inside DATA, then K.
        start_packet();
        rb = 8'($urandom);
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back(rb[b]);
            add_data(rb[b], 1'b1);
        end
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_K);
        for (int i = 0; i < 3; i++) sym_q.push_back($urandom_range(0, 1) ? SYM_J : SYM_K);
        play(sym_q.size());
        check_eq("glitch_no_eop", eop_cnt, 0);
        check_eq("glitch_active", rcv_active, 1'b1);
        sym_q.delete();
        add_eop();
        play(2);
        check_eq("glitch_eop_at_2nd_se0", obs_eop, 1'b1);
        send_sym(SYM_J);
        check_eq("glitch_active_after_j", rcv_active, 1'b0);
        check_eq("glitch_eop_count", eop_cnt, 1);
        compare_bits("glitch");

        // Asynchronous reset in the middle of a byte.
        start_packet();
        for (int b = 0; b < 4; b++) add_data(1'b1, 1'b1);
        play(sym_q.size());
        #2 n_rst = 1'b0;
        #1;
        check_eq("midreset_outputs", {data_out, data_valid, eop, stuff_err, rcv_active}, 5'b0);
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_no_eop", eop_cnt, 0);
        bytes_q = '{8'h3A};
        run_packet("after_reset_3a");

        check_eq("pulse_without_strobe", nostrobe_viol, 0);
        check_eq("data_out_hold", hold_viol, 0);
        check_eq("pulse_overlap", overlap_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
